decode_branch: RTL and testbench

//  - Decode stage paired with fetch: consumes bjinst/nxtadrsr, returns registered PCd/bj redirect.
//  - Decodes 16-bit instruction into registered execute-stage fields.
//  - Resolves JMP/BZ/BNZ/CALL/RET/HLT using a zero flag and a single-entry return-address register.

---
 rtl/decode_branch_pkg.sv | 50 +++++
 rtl/decode_branch_if.sv | 34 +++
 rtl/decode_branch_branch_resolve.sv | 79 +++++++
 rtl/decode_branch.sv | 179 +++++++++++++++++
 tb/tb_decode_branch.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/decode_branch_pkg.sv
// Shared definitions for the decode/branch stage: widths, opcode values,
// instruction field positions, FSM state encoding and small decode helpers.
package decode_branch_pkg;

    localparam int ADDR_W = 8;
    localparam int INST_W = 16;

    // Instruction field positions: [15:12] op, [11:8] rd, [7:4] rs, [7:0] imm8
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS_MSB  = 7;
    localparam int RS_LSB  = 4;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_LDI  = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_BZ   = 4'h9;
    localparam logic [3:0] OP_BNZ  = 4'hA;
    localparam logic [3:0] OP_CALL = 4'hB;
    localparam logic [3:0] OP_RET  = 4'hC;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    // D and E are the only unassigned opcodes.
    function automatic logic op_is_legal(input logic [3:0] op);
        return !(op == 4'hD || op == 4'hE);
    endfunction

    // Ops that write a destination register in execute.
    function automatic logic op_writes_reg(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_LDI) || (op == OP_LD);
    endfunction

endpackage

// File: rtl/decode_branch_if.sv
// Fetch/execute side bus of the decode stage.
//   master : fetch/execute side (drives bjinst, nxtadrsr, zf_in, zf_we)
//   slave  : decode stage (drives PCd, bj and the registered execute fields)
// There is no valid/ready handshake: an instruction is presented every
// cycle (16'h0000 = NOP/squash), and bj is a one-cycle-registered redirect
// request that fetch must obey on the cycle it sees it.
interface decode_branch_if;
    import decode_branch_pkg::*;

    logic [INST_W-1:0] bjinst;
    logic [ADDR_W-1:0] nxtadrsr;
    logic              zf_in;
    logic              zf_we;
    logic [ADDR_W-1:0] PCd;
    logic              bj;
    logic [3:0]        ex_op;
    logic [3:0]        ex_rd;
    logic [3:0]        ex_rs;
    logic [7:0]        ex_imm;
    logic              ex_we;
    logic              halted;
    logic              illegal;

    modport master (
        output bjinst, nxtadrsr, zf_in, zf_we,
        input  PCd, bj, ex_op, ex_rd, ex_rs, ex_imm, ex_we, halted, illegal
    );

    modport slave (
        input  bjinst, nxtadrsr, zf_in, zf_we,
        output PCd, bj, ex_op, ex_rd, ex_rs, ex_imm, ex_we, halted, illegal
    );

endinterface

// File: rtl/decode_branch_branch_resolve.sv
// Combinational control-flow resolution for one decoded instruction.
// Ports:
//   op_i, imm8_i, nxtadr_i      opcode, 8-bit immediate, address of instruction
//   zf_eff_i                    zero flag after same-cycle forwarding
//   ret_addr_i, ret_valid_i     single-entry return register
//   redirect_o, target_o        redirect request and its target
//   halt_o                      instruction is HLT
//   ret_push_o, ret_addr_new_o  CALL: load return register with nxtadr+1
//   ret_pop_o                   RET with a valid return address
//   ret_err_o                   RET while the return register is empty
module branch_resolve
    import decode_branch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic [3:0]        op_i,
    input  logic [ADDR_W-1:0] imm8_i,
    input  logic [ADDR_W-1:0] nxtadr_i,
    input  logic              zf_eff_i,
    input  logic [ADDR_W-1:0] ret_addr_i,
    input  logic              ret_valid_i,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] target_o,
    output logic              halt_o,
    output logic              ret_push_o,
    output logic [ADDR_W-1:0] ret_addr_new_o,
    output logic              ret_pop_o,
    output logic              ret_err_o
);

    always_comb begin
        redirect_o     = 1'b0;
        target_o       = nxtadr_i;
        halt_o         = 1'b0;
        ret_push_o     = 1'b0;
        ret_pop_o      = 1'b0;
        ret_err_o      = 1'b0;
        // Natural 8-bit wrap: a CALL at 0xFF returns to 0x00.
        ret_addr_new_o = nxtadr_i + {{(ADDR_W-1){1'b0}}, 1'b1};

        case (op_i)
            OP_JMP: begin
                redirect_o = 1'b1;
                target_o   = imm8_i;
            end
            OP_BZ: begin
                redirect_o = zf_eff_i;
                target_o   = imm8_i;
            end
            OP_BNZ: begin
                redirect_o = !zf_eff_i;
                target_o   = imm8_i;
            end
            OP_CALL: begin
                redirect_o = 1'b1;
                target_o   = imm8_i;
                ret_push_o = 1'b1;
            end
            OP_RET: begin
                redirect_o = 1'b1;
                if (ret_valid_i) begin
                    target_o  = ret_addr_i;
                    ret_pop_o = 1'b1;
                end else begin
                    target_o  = RESET_PC;
                    ret_err_o = 1'b1;
                end
            end
            OP_HLT: begin
                // Park fetch on the HLT instruction itself.
                redirect_o = 1'b1;
                target_o   = nxtadr_i;
                halt_o     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_branch.sv
// Decode stage paired with fetch. Decodes the instruction on bus.bjinst into
// registered execute fields and resolves control flow into a registered
// redirect (bus.bj / bus.PCd). Every output is registered, so there is no
// combinational path from bjinst to bj/PCd.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   bus          decode_branch_if.slave: bjinst, nxtadrsr, zf_in, zf_we in;
//                PCd, bj, ex_op/rd/rs/imm/we, halted, illegal out
//   dbg_state_o  current FSM state
module decode_branch
    import decode_branch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic           clk,
    input  logic           rst,
    decode_branch_if.slave bus,
    output state_e         dbg_state_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pcd_q, pcd_d;
    logic              bj_q, bj_d;
    logic [3:0]        ex_op_q, ex_op_d;
    logic [3:0]        ex_rd_q, ex_rd_d;
    logic [3:0]        ex_rs_q, ex_rs_d;
    logic [7:0]        ex_imm_q, ex_imm_d;
    logic              ex_we_q, ex_we_d;
    logic              halted_q, halted_d;
    logic              illegal_q, illegal_d;
    logic              zf_q, zf_d;
    logic [ADDR_W-1:0] ret_addr_q, ret_addr_d;
    logic              ret_valid_q, ret_valid_d;

    logic [3:0]        op;
    logic              zf_eff;
    logic              br_redirect;
    logic [ADDR_W-1:0] br_target;
    logic              br_halt;
    logic              br_push;
    logic [ADDR_W-1:0] br_ret_new;
    logic              br_pop;
    logic              br_err;

    assign op = bus.bjinst[OP_MSB:OP_LSB];
    // A flag written by execute this cycle is forwarded to the branch.
    assign zf_eff = bus.zf_we ? bus.zf_in : zf_q;

    branch_resolve #(
        .RESET_PC (RESET_PC)
    ) u_branch_resolve (
        .op_i           (op),
        .imm8_i         (bus.bjinst[IMM_MSB:IMM_LSB]),
        .nxtadr_i       (bus.nxtadrsr),
        .zf_eff_i       (zf_eff),
        .ret_addr_i     (ret_addr_q),
        .ret_valid_i    (ret_valid_q),
        .redirect_o     (br_redirect),
        .target_o       (br_target),
        .halt_o         (br_halt),
        .ret_push_o     (br_push),
        .ret_addr_new_o (br_ret_new),
        .ret_pop_o      (br_pop),
        .ret_err_o      (br_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pcd_d       = pcd_q;
        bj_d        = 1'b0;
        ex_op_d     = 4'h0;
        ex_rd_d     = 4'h0;
        ex_rs_d     = 4'h0;
        ex_imm_d    = 8'h00;
        ex_we_d     = 1'b0;
        halted_d    = halted_q;
        illegal_d   = 1'b0;
        ret_addr_d  = ret_addr_q;
        ret_valid_d = ret_valid_q;
        // The flag tracks execute in every state, including FLUSH and HALT.
        zf_d        = zf_eff;

        case (state_q)
            ST_RUN: begin
                if (op_is_legal(op)) begin
                    ex_op_d  = op;
                    ex_rd_d  = bus.bjinst[RD_MSB:RD_LSB];
                    ex_rs_d  = bus.bjinst[RS_MSB:RS_LSB];
                    ex_imm_d = bus.bjinst[IMM_MSB:IMM_LSB];
                    ex_we_d  = op_writes_reg(op);
                end else begin
                    illegal_d = 1'b1;
                end

                if (br_redirect) begin
                    bj_d    = 1'b1;
                    pcd_d   = br_target;
                    state_d = br_halt ? ST_HALT : ST_FLUSH;
                end
                if (br_halt) begin
                    halted_d = 1'b1;
                end
                if (br_push) begin
                    ret_addr_d  = br_ret_new;
                    ret_valid_d = 1'b1;
                end
                if (br_pop) begin
                    ret_valid_d = 1'b0;
                end
                if (br_err) begin
                    illegal_d = 1'b1;
                end
            end
            ST_FLUSH: begin
                // Instruction on bjinst is the wrong-path one fetched before
                // the redirect took effect; drop it.
                state_d = ST_RUN;
            end
            ST_HALT: begin
                bj_d     = 1'b1;
                halted_d = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcd_q       <= '0;
            bj_q        <= 1'b0;
            ex_op_q     <= 4'h0;
            ex_rd_q     <= 4'h0;
            ex_rs_q     <= 4'h0;
            ex_imm_q    <= 8'h00;
            ex_we_q     <= 1'b0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
            zf_q        <= 1'b0;
            ret_addr_q  <= '0;
            ret_valid_q <= 1'b0;
        end else begin
            pcd_q       <= pcd_d;
            bj_q        <= bj_d;
            ex_op_q     <= ex_op_d;
            ex_rd_q     <= ex_rd_d;
            ex_rs_q     <= ex_rs_d;
            ex_imm_q    <= ex_imm_d;
            ex_we_q     <= ex_we_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
            zf_q        <= zf_d;
            ret_addr_q  <= ret_addr_d;
            ret_valid_q <= ret_valid_d;
        end
    end

    assign bus.PCd      = pcd_q;
    assign bus.bj       = bj_q;
    assign bus.ex_op    = ex_op_q;
    assign bus.ex_rd    = ex_rd_q;
    assign bus.ex_rs    = ex_rs_q;
    assign bus.ex_imm   = ex_imm_q;
    assign bus.ex_we    = ex_we_q;
    assign bus.halted   = halted_q;
    assign bus.illegal  = illegal_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_decode_branch.sv
// Directed bench for decode_branch: a table of single-cycle vectors for the
// decode and branch paths, then hand-written sequences for reset, CALL/RET,
// HLT and reset during FLUSH. Inputs change on the falling edge and outputs
// are sampled on the following falling edge (one rising edge in between).
module tb_decode_branch;
    import decode_branch_pkg::*;

    logic   clk;
    logic   rst;
    state_e dbg_state;

    decode_branch_if bus ();

    decode_branch #(
        .RESET_PC (8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    // Packed view: {bj, PCd, ex_op, ex_rd, ex_rs, ex_imm, ex_we, halted, illegal}
    function automatic logic [31:0] mk(input logic bj, input logic [7:0] pcd,
                                       input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs, input logic [7:0] imm,
                                       input logic we, input logic h, input logic il);
        return {bj, pcd, op, rd, rs, imm, we, h, il};
    endfunction

    function automatic logic [31:0] actual();
        return {bus.bj, bus.PCd, bus.ex_op, bus.ex_rd, bus.ex_rs, bus.ex_imm,
                bus.ex_we, bus.halted, bus.illegal};
    endfunction

    task automatic check_out(input string name);
        logic [31:0] e;
        logic [31:0] a;
        e = exp_q.pop_front();
        a = actual();
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got bj=%b PCd=%h op=%h rd=%h rs=%h imm=%h we=%b halted=%b illegal=%b, expected %h (packed got %h)",
                     name, a[31], a[30:23], a[22:19], a[18:15], a[14:11], a[10:3],
                     a[2], a[1], a[0], e, a);
        end
    endtask

    task automatic check_state(input string name, input state_e exp_s);
        checks++;
        if (dbg_state !== exp_s) begin
            failures++;
            $display("FAIL %s: state got %0d expected %0d", name, dbg_state, exp_s);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic [15:0] inst, input logic [7:0] adr,
                        input logic zin, input logic zwe,
                        input logic [31:0] exp, input string name);
        bus.bjinst   = inst;
        bus.nxtadrsr = adr;
        bus.zf_in    = zin;
        bus.zf_we    = zwe;
        @(posedge clk);
        @(negedge clk);
        exp_q.push_back(exp);
        check_out(name);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] inst;
        logic [7:0]  adr;
        logic        zin;
        logic        zwe;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[22];

    initial begin
        rst          = 1'b1;
        bus.bjinst   = 16'h0000;
        bus.nxtadrsr = 8'h00;
        bus.zf_in    = 1'b0;
        bus.zf_we    = 1'b0;

        vecs[0]  = '{16'h1123, 8'h01, 1'b0, 1'b0, mk(0, 8'h00, 4'h1, 4'h1, 4'h2, 8'h23, 1, 0, 0)};
        vecs[1]  = '{16'h2456, 8'h02, 1'b0, 1'b0, mk(0, 8'h00, 4'h2, 4'h4, 4'h5, 8'h56, 1, 0, 0)};
        vecs[2]  = '{16'h3789, 8'h03, 1'b0, 1'b0, mk(0, 8'h00, 4'h3, 4'h7, 4'h8, 8'h89, 1, 0, 0)};
        vecs[3]  = '{16'h4ABC, 8'h04, 1'b0, 1'b0, mk(0, 8'h00, 4'h4, 4'hA, 4'hB, 8'hBC, 1, 0, 0)};
        vecs[4]  = '{16'h5312, 8'h05, 1'b0, 1'b0, mk(0, 8'h00, 4'h5, 4'h3, 4'h1, 8'h12, 1, 0, 0)};
        vecs[5]  = '{16'h6420, 8'h06, 1'b0, 1'b0, mk(0, 8'h00, 4'h6, 4'h4, 4'h2, 8'h20, 1, 0, 0)};
        vecs[6]  = '{16'h7531, 8'h07, 1'b0, 1'b0, mk(0, 8'h00, 4'h7, 4'h5, 4'h3, 8'h31, 0, 0, 0)};
        vecs[7]  = '{16'h0000, 8'h08, 1'b0, 1'b0, mk(0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 0)};
        vecs[8]  = '{16'hD123, 8'h09, 1'b0, 1'b0, mk(0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 1)};
        vecs[9]  = '{16'hE456, 8'h0A, 1'b0, 1'b0, mk(0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 1)};
        // JMP then the FLUSH cycle, whose instruction must be dropped
        vecs[10] = '{16'h8042, 8'h10, 1'b0, 1'b0, mk(1, 8'h42, 4'h8, 4'h0, 4'h4, 8'h42, 0, 0, 0)};
        vecs[11] = '{16'h1111, 8'h11, 1'b0, 1'b0, mk(0, 8'h42, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 0)};
        vecs[12] = '{16'h1FFF, 8'h42, 1'b0, 1'b0, mk(0, 8'h42, 4'h1, 4'hF, 4'hF, 8'hFF, 1, 0, 0)};
        // BZ with forwarded zf_in=1: taken
        vecs[13] = '{16'h9020, 8'h43, 1'b1, 1'b1, mk(1, 8'h20, 4'h9, 4'h0, 4'h2, 8'h20, 0, 0, 0)};
        vecs[14] = '{16'h0000, 8'h44, 1'b0, 1'b0, mk(0, 8'h20, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 0)};
        // BZ with forwarded zf_in=0: not taken, no FLUSH afterwards
        vecs[15] = '{16'h9030, 8'h20, 1'b0, 1'b1, mk(0, 8'h20, 4'h9, 4'h0, 4'h3, 8'h30, 0, 0, 0)};
        vecs[16] = '{16'h1123, 8'h21, 1'b0, 1'b0, mk(0, 8'h20, 4'h1, 4'h1, 4'h2, 8'h23, 1, 0, 0)};
        // BNZ using stored zf=0: taken
        vecs[17] = '{16'hA077, 8'h22, 1'b0, 1'b0, mk(1, 8'h77, 4'hA, 4'h0, 4'h7, 8'h77, 0, 0, 0)};
        // zf written during FLUSH must stick
        vecs[18] = '{16'h0000, 8'h23, 1'b1, 1'b1, mk(0, 8'h77, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 0)};
        vecs[19] = '{16'hA066, 8'h77, 1'b0, 1'b0, mk(0, 8'h77, 4'hA, 4'h0, 4'h6, 8'h66, 0, 0, 0)};
        vecs[20] = '{16'h9011, 8'h78, 1'b0, 1'b0, mk(1, 8'h11, 4'h9, 4'h0, 4'h1, 8'h11, 0, 0, 0)};
        vecs[21] = '{16'h0000, 8'h79, 1'b0, 1'b0, mk(0, 8'h11, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 0)};

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_q.push_back(mk(0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 0));
        check_out("reset_outputs");
        check_state("reset_state", ST_RUN);
        rst = 1'b0;

        // ---- table ----
        for (int i = 0; i < 22; i++) begin
            step(vecs[i].inst, vecs[i].adr, vecs[i].zin, vecs[i].zwe, vecs[i].exp,
                 $sformatf("vec%0d", i));
            if (i == 10) check_state("jmp_to_flush", ST_FLUSH);
            if (i == 15) check_state("bz_not_taken_run", ST_RUN);
        end

        // ---- CALL / RET ----
        do_reset(1);
        step(16'hB030, 8'hFF, 0, 0, mk(1, 8'h30, 4'hB, 4'h0, 4'h3, 8'h30, 0, 0, 0), "call_ff");
        step(16'h0000, 8'h00, 0, 0, mk(0, 8'h30, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 0), "call_flush");
        step(16'hC000, 8'h30, 0, 0, mk(1, 8'h00, 4'hC, 4'h0, 4'h0, 8'h00, 0, 0, 0), "ret_wrap");
        step(16'h0000, 8'h31, 0, 0, mk(0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 0), "ret_flush");
        step(16'hB050, 8'h20, 0, 0, mk(1, 8'h50, 4'hB, 4'h0, 4'h5, 8'h50, 0, 0, 0), "call_a");
        step(16'h0000, 8'h21, 0, 0, mk(0, 8'h50, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 0), "call_a_flush");
        step(16'hB060, 8'h40, 0, 0, mk(1, 8'h60, 4'hB, 4'h0, 4'h6, 8'h60, 0, 0, 0), "call_overwrite");
        step(16'h0000, 8'h41, 0, 0, mk(0, 8'h60, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 0), "call_b_flush");
        step(16'hC000, 8'h60, 0, 0, mk(1, 8'h41, 4'hC, 4'h0, 4'h0, 8'h00, 0, 0, 0), "ret_overwritten");
        step(16'h0000, 8'h61, 0, 0, mk(0, 8'h41, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 0), "ret2_flush");
        step(16'hC000, 8'h41, 0, 0, mk(1, 8'h00, 4'hC, 4'h0, 4'h0, 8'h00, 0, 0, 1), "ret_empty");
        step(16'h0000, 8'h42, 0, 0, mk(0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 0), "ret_empty_pulse_end");

        // ---- HLT ----
        do_reset(1);
        step(16'hF000, 8'h55, 0, 0, mk(1, 8'h55, 4'hF, 4'h0, 4'h0, 8'h00, 0, 1, 0), "hlt");
        check_state("hlt_state", ST_HALT);
        for (int i = 0; i < 20; i++) begin
            logic [15:0] junk;
            junk = 16'($urandom_range(0, 16'hFFFF));
            step(junk, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 mk(1, 8'h55, 4'h0, 4'h0, 4'h0, 8'h00, 0, 1, 0), $sformatf("halt_hold%0d", i));
        end
        do_reset(1);
        exp_q.push_back(mk(0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 0));
        check_out("halt_reset");
        check_state("halt_reset_state", ST_RUN);

        // ---- reset in the middle of FLUSH, with zf and ret set beforehand ----
        step(16'h0000, 8'h00, 1, 1, mk(0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 0), "set_zf");
        step(16'hB0AA, 8'h10, 0, 0, mk(1, 8'hAA, 4'hB, 4'h0, 4'hA, 8'hAA, 0, 0, 0), "call_before_rst");
        do_reset(2);
        exp_q.push_back(mk(0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 0));
        check_out("flush_reset");
        check_state("flush_reset_state", ST_RUN);
        // zf cleared by reset: BZ not taken
        step(16'h9033, 8'h00, 0, 0, mk(0, 8'h00, 4'h9, 4'h0, 4'h3, 8'h33, 0, 0, 0), "bz_after_rst");
        // ret_valid cleared by reset: RET goes to RESET_PC and flags illegal
        step(16'hC000, 8'h01, 0, 0, mk(1, 8'h00, 4'hC, 4'h0, 4'h0, 8'h00, 0, 0, 1), "ret_after_rst");
        step(16'h2345, 8'h02, 0, 0, mk(0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 0), "ret_after_rst_flush");
        step(16'h2345, 8'h00, 0, 0, mk(0, 8'h00, 4'h2, 4'h3, 4'h4, 8'h45, 1, 0, 0), "sub_after_flush");

        // ---- final report ----
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
